// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants for the instruction fetch stage.
package mips_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    // Instruction word plus its fall-through address, as handed to decode.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus_4;
    } if_payload_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory port, decode handshake and redirect input.
interface instruction_fetch_if;
    import mips_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    logic [XLEN-1:0] next_instruction;
    logic [XLEN-1:0] pc_plus_4;
    logic            if_valid;
    logic            id_ready;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;

    logic            fetch_err;

    modport master (
        output imem_req, imem_addr, next_instruction, pc_plus_4, if_valid, fetch_err,
        input  imem_ack, imem_rdata, id_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, next_instruction, pc_plus_4, if_valid, fetch_err,
        output imem_ack, imem_rdata, id_ready, redirect_valid, redirect_target
    );

endinterface

// File: rtl/instruction_fetch.sv
// MIPS IF stage: one outstanding imem fetch, valid/ready hand-off to decode,
// redirect with squash of the in-flight request, and a fetch timeout.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    localparam int unsigned     TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [XLEN-1:0] PC_INIT  = word_align(RESET_PC);

    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             squash_q, squash_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             valid_q, valid_d;
    if_payload_t      out_q, out_d;
    logic             err_q, err_d;

    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  pc_inc;

    assign target = word_align(bus.redirect_target);
    assign pc_inc = pc_q + XLEN'(WORD_BYTES);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_REQ;
            pc_q     <= PC_INIT;
            squash_q <= 1'b0;
            tmo_q    <= '0;
            valid_q  <= 1'b0;
            out_q    <= '{instr: INSTR_NOP, pc_plus_4: '0};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            tmo_q    <= tmo_d;
            valid_q  <= valid_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        tmo_d    = tmo_q;
        valid_d  = valid_q;
        out_d    = out_q;
        err_d    = err_q;

        unique case (state_q)
            S_REQ: begin
                state_d = S_WAIT;
                tmo_d   = '0;
                if (bus.imem_ack) begin
                    err_d = 1'b1;
                end
                // The request goes out with the old pc; mark it for discard.
                if (bus.redirect_valid) begin
                    pc_d     = target;
                    squash_d = 1'b1;
                end
            end

            S_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (bus.imem_ack && (squash_q || bus.redirect_valid)) begin
                    squash_d = 1'b0;
                    if (bus.redirect_valid) begin
                        pc_d = target;
                    end
                    state_d = S_REQ;
                end else if (bus.imem_ack) begin
                    out_d   = '{instr: bus.imem_rdata, pc_plus_4: pc_inc};
                    pc_d    = pc_inc;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else if (bus.redirect_valid) begin
                    pc_d     = target;
                    squash_d = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    // Abandon the lost request and reissue whatever pc now holds.
                    err_d    = 1'b1;
                    squash_d = 1'b0;
                    state_d  = S_REQ;
                end
            end

            S_HOLD: begin
                if (bus.imem_ack) begin
                    err_d = 1'b1;
                end
                if (bus.redirect_valid) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (bus.id_ready) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign bus.imem_req         = (state_q == S_REQ);
    assign bus.imem_addr        = (state_q == S_REQ) ? pc_q : XLEN'(0);
    assign bus.next_instruction = out_q.instr;
    assign bus.pc_plus_4        = out_q.pc_plus_4;
    assign bus.if_valid         = valid_q;
    assign bus.fetch_err        = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; inputs change and outputs are sampled on negedge.
module tb_instruction_fetch;

    localparam int unsigned TIMEOUT = 16;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        check32("req_seen", 32'(bus.imem_req), 32'd1);
    endtask

    // Issue-side check, one-cycle ack, then land in HOLD and check the payload.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] nxt;
        nxt = addr + 32'd4;
        wait_req();
        check32("fetch_addr", bus.imem_addr, addr);
        step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        check32("hold_valid", 32'(bus.if_valid), 32'd1);
        check32("hold_instr", bus.next_instruction, data);
        check32("hold_pc4", bus.pc_plus_4, nxt);
    endtask

    task automatic accept();
        bus.id_ready = 1'b1;
        step();
        bus.id_ready = 1'b0;
        check32("accept_valid", 32'(bus.if_valid), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.imem_ack        = 1'b0;
        bus.imem_rdata      = 32'h0;
        bus.id_ready        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        @(negedge clk);
        step();

        check32("rst_valid", 32'(bus.if_valid), 32'd0);
        check32("rst_instr", bus.next_instruction, 32'h0);
        check32("rst_pc4", bus.pc_plus_4, 32'h0);
        check32("rst_err", 32'(bus.fetch_err), 32'd0);
        check32("rst_req", 32'(bus.imem_req), 32'd1);
        check32("rst_addr", bus.imem_addr, 32'h0);
        reset = 1'b0;

        // Back-to-back fetches at 0 and 4.
        fetch(32'h0, 32'h2008_0005);
        accept();
        fetch(32'h4, 32'h2008_0005);
        accept();

        // No ack at pc=8: error after TIMEOUT wait cycles, same address reissued.
        wait_req();
        check32("tmo_addr", bus.imem_addr, 32'h8);
        check32("tmo_err_pre", 32'(bus.fetch_err), 32'd0);
        step();
        for (int i = 0; i < int'(TIMEOUT) - 1; i++) step();
        check32("tmo_err_late", 32'(bus.fetch_err), 32'd0);
        check32("tmo_req_late", 32'(bus.imem_req), 32'd0);
        step();
        check32("tmo_err", 32'(bus.fetch_err), 32'd1);
        check32("tmo_reissue", 32'(bus.imem_req), 32'd1);
        check32("tmo_readdr", bus.imem_addr, 32'h8);

        // Stall decode for 5 cycles in HOLD.
        fetch(32'h8, 32'h8C22_0010);
        for (int i = 0; i < 5; i++) begin
            step();
            check32("stall_valid", 32'(bus.if_valid), 32'd1);
            check32("stall_instr", bus.next_instruction, 32'h8C22_0010);
            check32("stall_pc4", bus.pc_plus_4, 32'hC);
            check32("stall_req", 32'(bus.imem_req), 32'd0);
        end
        accept();

        // Redirect in WAIT; the late ack's data is discarded.
        wait_req();
        check32("rdw_addr", bus.imem_addr, 32'hC);
        step();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0043;
        step();
        bus.redirect_valid  = 1'b0;
        check32("rdw_valid0", 32'(bus.if_valid), 32'd0);
        step();
        check32("rdw_valid1", 32'(bus.if_valid), 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        bus.imem_ack   = 1'b0;
        check32("rdw_valid2", 32'(bus.if_valid), 32'd0);
        check32("rdw_req", 32'(bus.imem_req), 32'd1);
        check32("rdw_addr2", bus.imem_addr, 32'h40);

        // Redirect wins over id_ready in HOLD.
        fetch(32'h40, 32'h0123_4567);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0100;
        bus.id_ready        = 1'b1;
        step();
        bus.redirect_valid  = 1'b0;
        bus.id_ready        = 1'b0;
        check32("rdh_valid", 32'(bus.if_valid), 32'd0);
        check32("rdh_req", 32'(bus.imem_req), 32'd1);
        check32("rdh_addr", bus.imem_addr, 32'h100);
        fetch(32'h100, 32'h1000_FFFF);
        accept();

        // Reset clears the sticky error; then an ack during HOLD sets it.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check32("rst2_err", 32'(bus.fetch_err), 32'd0);
        check32("rst2_addr", bus.imem_addr, 32'h0);
        fetch(32'h0, 32'h2008_0005);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        step();
        bus.imem_ack   = 1'b0;
        check32("hack_err", 32'(bus.fetch_err), 32'd1);
        check32("hack_valid", 32'(bus.if_valid), 32'd1);
        check32("hack_instr", bus.next_instruction, 32'h2008_0005);
        check32("hack_pc4", bus.pc_plus_4, 32'h4);
        accept();

        // Reset mid-WAIT; a stale ack in the following REQ is unexpected.
        wait_req();
        check32("mrst_addr", bus.imem_addr, 32'h4);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check32("mrst_err0", 32'(bus.fetch_err), 32'd0);
        check32("mrst_req", 32'(bus.imem_req), 32'd1);
        check32("mrst_raddr", bus.imem_addr, 32'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        bus.imem_ack   = 1'b0;
        check32("stale_err", 32'(bus.fetch_err), 32'd1);
        check32("stale_valid", 32'(bus.if_valid), 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h2008_0005;
        step();
        bus.imem_ack   = 1'b0;
        check32("stale_hold", 32'(bus.if_valid), 32'd1);
        check32("stale_pc4", bus.pc_plus_4, 32'h4);
        accept();

        // Redirect in REQ with unaligned target, then pc wrap at the top of memory.
        wait_req();
        check32("rdr_addr", bus.imem_addr, 32'h4);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFE;
        step();
        bus.redirect_valid  = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAAD_F00D;
        step();
        bus.imem_ack   = 1'b0;
        check32("rdr_valid", 32'(bus.if_valid), 32'd0);
        fetch(32'hFFFF_FFFC, 32'h0800_0000);
        accept();
        wait_req();
        check32("wrap_addr", bus.imem_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the MIPS pipeline and the producer of the decode stage's instruction word.
- Holds the PC and issues word fetches to an external instruction memory with one outstanding request. Responses may arrive after a variable latency.
- Presents each fetched instruction to decode under a valid/ready handshake, and takes branch/jump redirects from later stages, squashing any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- TIMEOUT, 16, max cycles spent in WAIT before the request is abandoned and reissued; must be >= 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request strobe; high exactly while state==S_REQ.
- imem_addr  out  32  fetch address; equals pc while imem_req is high, otherwise 0.
- imem_ack  in  1  one-cycle response strobe from memory.
- imem_rdata  in  32  instruction word; valid only with imem_ack.
- next_instruction  out  32  instruction presented to decode.
- pc_plus_4  out  32  address of presented instruction + 4.
- if_valid  out  1  next_instruction/pc_plus_4 are valid.
- id_ready  in  1  decode accepts the presented instruction this cycle.
- redirect_valid  in  1  branch/jump taken; the target replaces the PC.
- redirect_target  in  32  new PC; bits [1:0] are ignored and forced to 0.
- fetch_err  out  1  sticky error flag: unexpected ack or timeout.

Behaviour:
- Reset (synchronous, reset=1 at posedge):
  - pc=RESET_PC, state=S_REQ, squash=0, tmo_cnt=0.
  - if_valid=0, next_instruction=0, pc_plus_4=0, fetch_err=0.
  - Reset overrides every other input in the same cycle, including a mid-fetch reset: a late ack after reset is treated as unexpected.
- States: S_REQ, S_WAIT, S_HOLD. All outputs except imem_req/imem_addr are registered.
- S_REQ:
  - imem_req=1 for one cycle. Next state S_WAIT, tmo_cnt cleared.
  - If redirect_valid: pc<=target, squash<=1; the issued request is discarded on its return.
- S_WAIT, each cycle tmo_cnt increments. Evaluated in this priority order:
  - imem_ack && (squash || redirect_valid): discard the data. squash<=0. If redirect_valid, pc<=target. Go to S_REQ.
  - imem_ack (clean): next_instruction<=imem_rdata, pc_plus_4<=pc+4, pc<=pc+4, if_valid<=1. Go to S_HOLD.
  - redirect_valid without ack: pc<=target, squash<=1. Stay in S_WAIT.
  - tmo_cnt==TIMEOUT-1 without ack: fetch_err<=1, squash<=0, go to S_REQ, reissuing the same pc.
- S_HOLD (if_valid=1; next_instruction and pc_plus_4 stable):
  - redirect_valid has priority over the handshake. if_valid<=0, pc<=target, go to S_REQ. The held instruction is dropped even if id_ready=1 in the same cycle.
  - Else if id_ready: handshake completes, if_valid<=0, go to S_REQ.
  - Else hold unchanged for any number of cycles.
- Error conditions:
  - imem_ack in S_REQ or S_HOLD: fetch_err<=1, data ignored, no state change.
  - fetch_err clears only on reset.
- Arithmetic: pc+4 is a 32-bit add; wrap from 32'hFFFF_FFFC to 0 is legal and not an error.
- Latency: minimum 3 cycles per instruction (REQ, WAIT with same-cycle-next ack, HOLD with id_ready=1). The first imem_req is in the first cycle after reset deasserts.

Decomposition:
- Shared package mips_pkg:
  - fetch_state_t enum {S_REQ, S_WAIT, S_HOLD}.
  - WORD_BYTES=4.
  - INSTR_NOP=32'h0000_0000.
- Single module; no sub-module is warranted. The timeout counter is an inline $clog2(TIMEOUT)-bit register.

Test Plan:
- Reset then ack 1 cycle after each req with rdata=32'h2008_0005, id_ready=1 -> imem_addr sequence 0,4,8; next_instruction=32'h2008_0005, pc_plus_4=4 on the first if_valid; fetch_err=0.
- Hold id_ready=0 for 5 cycles in S_HOLD -> if_valid stays 1, next_instruction and pc_plus_4 unchanged, imem_req=0 throughout; release -> next imem_addr=pc_plus_4.
- Redirect_valid with target 32'h0000_0043 in S_WAIT, ack 2 cycles later with 32'hDEAD_BEEF -> data discarded, if_valid never 1, next imem_addr=32'h0000_0040.
- Redirect and id_ready same cycle in S_HOLD with target 32'h100 -> if_valid falls, next imem_addr=32'h100, held instruction not counted as accepted.
- No ack for TIMEOUT cycles at pc=8 -> fetch_err=1, imem_req reissued with imem_addr=8; an ack while in S_HOLD also sets fetch_err.
- Reset asserted while in S_WAIT, then a stale ack arrives 1 cycle after reset deasserts in S_REQ -> fetch_err=1, if_valid=0, imem_addr=RESET_PC.
